// File: rtl/hqm_assertion_fifo_arb.sv
// Round-robin push arbiter and pop gate for a shared hqm_assertion_fifo.
// Tracks occupancy, the high-water mark and sticky overflow-attempt and underflow flags.
module hqm_assertion_fifo_arb #(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 8,
  parameter int DWIDTH  = 16,
  parameter int RWIDTH  = $clog2(NUM_REQ),
  parameter int CWIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_v,
  input  logic [NUM_REQ*DWIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_gnt,
  input  logic                      pop_req,
  output logic                      pop_ack,
  input  logic                      err_clr,
  output logic                      fifo_push,
  output logic [DWIDTH-1:0]         fifo_push_data,
  output logic                      fifo_pop,
  output logic [CWIDTH-1:0]         occupancy,
  output logic [CWIDTH-1:0]         hwm,
  output logic                      empty,
  output logic                      full,
  output logic                      err_underflow,
  output logic                      err_stall
);

  // Handshake: req_v[i] is held with req_data until req_gnt[i] is seen in the same cycle;
  // pop_req completes only in a cycle where pop_ack is high.

  logic [RWIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [CWIDTH-1:0] occupancy_q, occupancy_d;
  logic [CWIDTH-1:0] hwm_q, hwm_d;
  logic              err_underflow_q, err_underflow_d;
  logic              err_stall_q, err_stall_d;

  logic [RWIDTH-1:0] gnt_idx;
  logic [RWIDTH-1:0] cand;
  logic              found;

  assign empty = (occupancy_q == '0);
  assign full  = (occupancy_q == CWIDTH'(DEPTH));

  // Search cyclically from rr_ptr; no grant at all while full, even with a same-cycle pop.
  always_comb begin
    req_gnt = '0;
    gnt_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = RWIDTH'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && !full && req_v[cand]) begin
        found         = 1'b1;
        gnt_idx       = cand;
        req_gnt[cand] = 1'b1;
      end
    end
  end

  assign fifo_push      = found;
  assign fifo_push_data = found ? req_data[int'(gnt_idx)*DWIDTH +: DWIDTH] : '0;
  assign fifo_pop       = pop_req & ~empty;
  assign pop_ack        = fifo_pop;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (fifo_push) begin
      rr_ptr_d = (gnt_idx == RWIDTH'(NUM_REQ - 1)) ? '0 : gnt_idx + RWIDTH'(1);
    end
    occupancy_d     = occupancy_q + CWIDTH'(fifo_push) - CWIDTH'(fifo_pop);
    hwm_d           = (occupancy_d > hwm_q) ? occupancy_d : hwm_q;
    // A set condition in the clearing cycle takes priority over err_clr.
    err_underflow_d = (pop_req & empty) | (err_underflow_q & ~err_clr);
    err_stall_d     = ((|req_v) & full) | (err_stall_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q        <= '0;
      occupancy_q     <= '0;
      hwm_q           <= '0;
      err_underflow_q <= 1'b0;
      err_stall_q     <= 1'b0;
    end else begin
      rr_ptr_q        <= rr_ptr_d;
      occupancy_q     <= occupancy_d;
      hwm_q           <= hwm_d;
      err_underflow_q <= err_underflow_d;
      err_stall_q     <= err_stall_d;
    end
  end

  assign occupancy     = occupancy_q;
  assign hwm           = hwm_q;
  assign err_underflow = err_underflow_q;
  assign err_stall     = err_stall_q;

endmodule

// File: tb/tb_hqm_assertion_fifo_arb.sv
// Directed bench for hqm_assertion_fifo_arb: fill, drain, error flags, mixed push/pop, reset.
module tb_hqm_assertion_fifo_arb;

  localparam int NUM_REQ = 4;
  localparam int DEPTH   = 8;
  localparam int DWIDTH  = 16;
  localparam int CWIDTH  = 4;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_v;
  logic [NUM_REQ*DWIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]        req_gnt;
  logic                      pop_req;
  logic                      pop_ack;
  logic                      err_clr;
  logic                      fifo_push;
  logic [DWIDTH-1:0]         fifo_push_data;
  logic                      fifo_pop;
  logic [CWIDTH-1:0]         occupancy;
  logic [CWIDTH-1:0]         hwm;
  logic                      empty;
  logic                      full;
  logic                      err_underflow;
  logic                      err_stall;

  int checks = 0;
  int errors = 0;

  hqm_assertion_fifo_arb #(
    .NUM_REQ(NUM_REQ),
    .DEPTH  (DEPTH),
    .DWIDTH (DWIDTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_v         (req_v),
    .req_data      (req_data),
    .req_gnt       (req_gnt),
    .pop_req       (pop_req),
    .pop_ack       (pop_ack),
    .err_clr       (err_clr),
    .fifo_push     (fifo_push),
    .fifo_push_data(fifo_push_data),
    .fifo_pop      (fifo_pop),
    .occupancy     (occupancy),
    .hwm           (hwm),
    .empty         (empty),
    .full          (full),
    .err_underflow (err_underflow),
    .err_stall     (err_stall)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n   = 1'b0;
    req_v   = '0;
    pop_req = 1'b0;
    err_clr = 1'b0;
    req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    @(negedge clk);
    #1;
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
    checks++; if (hwm !== 4'd0) begin errors++; $display("FAIL reset_hwm got %0d exp 0", hwm); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags got empty=%b full=%b exp 1/0", empty, full); end
    checks++; if (req_gnt !== 4'b0000 || fifo_push !== 1'b0 || pop_ack !== 1'b0) begin errors++; $display("FAIL reset_idle got gnt=%b push=%b ack=%b exp 0", req_gnt, fifo_push, pop_ack); end
    checks++; if (err_underflow !== 1'b0 || err_stall !== 1'b0) begin errors++; $display("FAIL reset_err got %b%b exp 00", err_underflow, err_stall); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    logic [3:0]  exp_g;
    logic [15:0] exp_d;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      req_v = 4'b1111;
      #1;
      exp_g = 4'(1 << (k % 4));
      exp_d = 16'(16'h1111 * ((k % 4) + 1));
      checks++; if (req_gnt !== exp_g) begin errors++; $display("FAIL fill_gnt[%0d] got %b exp %b", k, req_gnt, exp_g); end
      checks++; if (fifo_push !== 1'b1 || fifo_push_data !== exp_d) begin errors++; $display("FAIL fill_data[%0d] got %b/%h exp 1/%h", k, fifo_push, fifo_push_data, exp_d); end
      @(posedge clk);
      #1;
      checks++; if (occupancy !== 4'(k + 1)) begin errors++; $display("FAIL fill_occ[%0d] got %0d exp %0d", k, occupancy, k + 1); end
    end
    @(negedge clk);
    #1;
    checks++; if (req_gnt !== 4'b0000 || fifo_push !== 1'b0) begin errors++; $display("FAIL full_gnt got %b/%b exp 0000/0", req_gnt, fifo_push); end
    checks++; if (full !== 1'b1 || empty !== 1'b0) begin errors++; $display("FAIL full_flag got full=%b empty=%b exp 1/0", full, empty); end
    @(posedge clk);
    #1;
    checks++; if (err_stall !== 1'b1) begin errors++; $display("FAIL stall_err got %b exp 1", err_stall); end
    checks++; if (hwm !== 4'd8 || occupancy !== 4'd8) begin errors++; $display("FAIL fill_hwm got hwm=%0d occ=%0d exp 8/8", hwm, occupancy); end
    @(negedge clk);
    req_v = '0;
  endtask

  task automatic test_drain();
    for (int k = 0; k < 8; k++) begin
      pop_req = 1'b1;
      #1;
      checks++; if (pop_ack !== 1'b1 || fifo_pop !== 1'b1) begin errors++; $display("FAIL drain_ack[%0d] got %b/%b exp 1/1", k, pop_ack, fifo_pop); end
      @(posedge clk);
      #1;
      checks++; if (occupancy !== 4'(7 - k)) begin errors++; $display("FAIL drain_occ[%0d] got %0d exp %0d", k, occupancy, 7 - k); end
      @(negedge clk);
    end
    #1;
    checks++; if (pop_ack !== 1'b0 || fifo_pop !== 1'b0) begin errors++; $display("FAIL empty_pop got %b/%b exp 0/0", pop_ack, fifo_pop); end
    @(posedge clk);
    #1;
    checks++; if (err_underflow !== 1'b1 || empty !== 1'b1 || occupancy !== 4'd0) begin errors++; $display("FAIL underflow got err=%b empty=%b occ=%0d exp 1/1/0", err_underflow, empty, occupancy); end
    checks++; if (hwm !== 4'd8) begin errors++; $display("FAIL hwm_hold got %0d exp 8", hwm); end
  endtask

  task automatic test_err_clr();
    @(negedge clk);
    err_clr = 1'b1;
    pop_req = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL clr_set_wins got %b exp 1", err_underflow); end
    checks++; if (err_stall !== 1'b0) begin errors++; $display("FAIL clr_stall got %b exp 0", err_stall); end
    @(negedge clk);
    pop_req = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL clr_underflow got %b exp 0", err_underflow); end
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic test_push_pop();
    for (int k = 0; k < 3; k++) begin
      req_v = 4'b0001;
      #1;
      checks++; if (req_gnt !== 4'b0001) begin errors++; $display("FAIL pp_fill_gnt[%0d] got %b exp 0001", k, req_gnt); end
      @(negedge clk);
    end
    #1;
    checks++; if (occupancy !== 4'd3) begin errors++; $display("FAIL pp_occ3 got %0d exp 3", occupancy); end
    req_v   = 4'b0100;
    pop_req = 1'b1;
    #1;
    checks++; if (req_gnt !== 4'b0100 || pop_ack !== 1'b1 || fifo_push_data !== 16'h3333) begin errors++; $display("FAIL pp_both got gnt=%b ack=%b data=%h exp 0100/1/3333", req_gnt, pop_ack, fifo_push_data); end
    @(posedge clk);
    #1;
    checks++; if (occupancy !== 4'd3) begin errors++; $display("FAIL pp_occ_hold got %0d exp 3", occupancy); end
    @(negedge clk);
    pop_req = 1'b0;
    req_v   = 4'b1001;
    #1;
    checks++; if (req_gnt !== 4'b1000 || fifo_push_data !== 16'h4444) begin errors++; $display("FAIL rr_next got %b/%h exp 1000/4444", req_gnt, fifo_push_data); end
    @(negedge clk);
    req_v = 4'b0001;
    #1;
    checks++; if (req_gnt !== 4'b0001) begin errors++; $display("FAIL rr_wrap got %b exp 0001", req_gnt); end
    @(posedge clk);
    #1;
    checks++; if (occupancy !== 4'd5) begin errors++; $display("FAIL pp_occ5 got %0d exp 5", occupancy); end
    @(negedge clk);
    req_v = '0;
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      req_v = 4'b0001;
      @(negedge clk);
    end
    req_v   = '0;
    pop_req = 1'b1;
    @(negedge clk);
    pop_req = 1'b0;
    #1;
    checks++; if (occupancy !== 4'd5 || hwm !== 4'd6) begin errors++; $display("FAIL pre_rst got occ=%0d hwm=%0d exp 5/6", occupancy, hwm); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (occupancy !== 4'd0 || hwm !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL async_rst got occ=%0d hwm=%0d empty=%b exp 0/0/1", occupancy, hwm, empty); end
    @(negedge clk);
    rst_n = 1'b1;
    req_v = 4'b1111;
    #1;
    checks++; if (req_gnt !== 4'b0001 || fifo_push_data !== 16'h1111) begin errors++; $display("FAIL post_rst_gnt got %b/%h exp 0001/1111", req_gnt, fifo_push_data); end
    @(negedge clk);
    req_v = '0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_err_clr();
    test_push_pop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
